// File: rtl/event_blinker_pkg.sv
// Shared definitions for event_blinker: FSM state encoding and timer sizing helper.
package blink_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;

  // Bits needed to hold max(a,b)-1, never less than one bit.
  function automatic int clog2_max(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/event_blinker_if.sv
// Event strobe in, LED/status out; master drives events, slave is the blinker.
interface event_blinker_if #(
    parameter int PEND_W = 4
);
    logic              pulse;
    logic              clr_ovf;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse, clr_ovf,
        input  led, busy, pending, overflow
    );

    modport slave (
        input  pulse, clr_ovf,
        output led, busy, pending, overflow
    );
endinterface

// File: rtl/cycle_timer.sv
// Load-and-count-down timer; zero flags a terminal count of 0 and the count holds there.
module cycle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/event_blinker.sv
// Turns one-cycle event pulses into ON/OFF LED flashes, queuing events that arrive mid-flash.
module event_blinker
    import blink_pkg::*;
#(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int OFF_CYCLES = 10_000_000,
    parameter int PEND_W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    event_blinker_if.slave bus
);

    localparam int                TW       = clog2_max(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_led;
    logic              r_busy;
    logic              w_led_nxt;
    logic              w_busy_nxt;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;

    logic              w_timer_zero;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_req;
    logic              w_start;
    logic              w_inc;
    logic              w_dec;
    logic              w_sat;

    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_timer_zero)
    );

    // A flash starts from IDLE, or straight from the last OFF cycle when work is waiting.
    assign w_req   = bus.pulse || (r_pending != '0);
    assign w_start = w_req && ((r_state == ST_IDLE) ||
                               ((r_state == ST_OFF) && w_timer_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req)        w_state_nxt = ST_ON;
            ST_ON:   if (w_timer_zero) w_state_nxt = ST_OFF;
            ST_OFF:  if (w_timer_zero) w_state_nxt = w_req ? ST_ON : ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load     = w_start || ((r_state == ST_ON) && w_timer_zero);
        w_load_val = w_start ? ON_LOAD : OFF_LOAD;
        w_led_nxt  = (w_state_nxt == ST_ON);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // A pulse that starts a flash is consumed on the spot; only mid-flash pulses are queued.
    assign w_inc = bus.pulse && !w_start && (r_state != ST_IDLE);
    assign w_dec = w_start && !bus.pulse;
    assign w_sat = w_inc && (r_pending == PEND_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_dec) begin
                r_pending <= r_pending - PEND_W'(1);
            end else if (w_inc && !w_sat) begin
                r_pending <= r_pending + PEND_W'(1);
            end

            if (w_sat) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.led      = r_led;
    assign bus.busy     = r_busy;
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
module tb_event_blinker;

    logic clk;
    logic rst_n;

    event_blinker_if #(.PEND_W(2)) bus ();

    event_blinker #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (3),
        .PEND_W     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run traces: bit i holds the outputs seen just after edge i of the run.
    logic [31:0] led_t;
    logic [31:0] busy_t;
    logic [31:0] ovf_t;
    logic [63:0] pend_t;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [1:0] pend_at(input int i);
        return pend_t[2*i +: 2];
    endfunction

    // Drives pulse/clr_ovf pattern bit i before edge i, then samples 1 time unit after it.
    task automatic run(input int n, input logic [31:0] pulse_pat, input logic [31:0] clr_pat);
        led_t  = '0;
        busy_t = '0;
        ovf_t  = '0;
        pend_t = '0;
        for (int i = 0; i < n; i++) begin
            bus.pulse   = pulse_pat[i];
            bus.clr_ovf = clr_pat[i];
            @(posedge clk);
            #1;
            led_t[i]        = bus.led;
            busy_t[i]       = bus.busy;
            ovf_t[i]        = bus.overflow;
            pend_t[2*i +: 2] = bus.pending;
        end
        bus.pulse   = 1'b0;
        bus.clr_ovf = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.pulse   = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led",      bus.led,      0);
        check("reset_busy",     bus.busy,     0);
        check("reset_pending",  bus.pending,  0);
        check("reset_overflow", bus.overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single pulse: 4 cycles lit, 3 dark, idle on the 8th sample.
        run(8, 32'h1, 32'h0);
        check("single_led",  led_t[7:0],  8'h0F);
        check("single_busy", busy_t[7:0], 8'h7F);
        check("single_pend", pend_t[15:0], 16'h0);

        // Three consecutive pulses: period-7 flashes, no idle gap.
        run(22, 32'h7, 32'h0);
        check("b2b_led",    led_t[21:0],  22'h03C78F);
        check("b2b_busy",   busy_t[21:0], 22'h1FFFFF);
        check("b2b_pend1",  pend_at(1),  1);
        check("b2b_pend2",  pend_at(2),  2);
        check("b2b_pend6",  pend_at(6),  2);
        check("b2b_pend7",  pend_at(7),  1);
        check("b2b_pend14", pend_at(14), 0);

        // Five pulses during one flash: saturate at 3, overflow, four flashes total.
        run(29, 32'h3F, 32'h0);
        check("ovf_led",    led_t[28:0],  29'h01E3C78F);
        check("ovf_busy",   busy_t[28:0], 29'h0FFFFFFF);
        check("ovf_pend3",  pend_at(3),  3);
        check("ovf_pend5",  pend_at(5),  3);
        check("ovf_flag3",  ovf_t[3],    0);
        check("ovf_flag4",  ovf_t[4],    1);
        check("ovf_flag28", ovf_t[28],   1);
        run(1, 32'h0, 32'h1);
        check("ovf_clr", ovf_t[0], 0);

        // Pulse on the last OFF cycle with one queued: straight into ON, pending holds at 1.
        run(22, 32'h83, 32'h0);
        check("coll_led",    led_t[21:0],  22'h03C78F);
        check("coll_busy",   busy_t[21:0], 22'h1FFFFF);
        check("coll_pend6",  pend_at(6),  1);
        check("coll_pend7",  pend_at(7),  1);
        check("coll_pend13", pend_at(13), 1);
        check("coll_pend14", pend_at(14), 0);

        // clr_ovf together with a saturating pulse: set wins; clear alone next cycle.
        run(29, 32'h1F, 32'h30);
        check("race_flag3", ovf_t[3], 0);
        check("race_flag4", ovf_t[4], 1);
        check("race_flag5", ovf_t[5], 0);
        check("race_led",   led_t[28:0], 29'h01E3C78F);
        check("race_idle",  busy_t[28], 0);

        // Reset mid-ON with two queued.
        run(3, 32'h7, 32'h0);
        check("rst_pre_led",  led_t[2],   1);
        check("rst_pre_pend", pend_at(2), 2);
        rst_n = 1'b0;
        #1;
        check("rst_led_async", bus.led,     0);
        check("rst_pend",      bus.pending, 0);
        check("rst_busy",      bus.busy,    0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(20, 32'h0, 32'h0);
        check("post_rst_led",  led_t[19:0],  20'h0);
        check("post_rst_busy", busy_t[19:0], 20'h0);
        check("post_rst_ovf",  ovf_t[19:0],  20'h0);
        check("post_rst_pend", pend_t[39:0], 40'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/event_blinker.md
# event_blinker

Converts single-cycle event pulses into human-visible LED flashes, one flash per event. It sits downstream of the button debouncer, taking its one-cycle `active` pulse, and drives board LEDs. Events that arrive during a flash are queued in a saturating counter and replayed in order. Overflow is flagged rather than silently dropped.

## Interface
- `ON_CYCLES`, default 10_000_000: LED-high duration per flash, in clk cycles; must be ≥1.
- `OFF_CYCLES`, default 10_000_000: mandatory LED-low gap after each flash, in clk cycles; must be ≥1.
- `PEND_W`, default 4: width of the pending-event counter; maximum queue depth is 2^PEND_W−1.

- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pulse` in 1: event strobe, one cycle per event (debouncer output).
- `clr_ovf` in 1: synchronous clear of `overflow`.
- `led` out 1: flash output.
- `busy` out 1: high in any state other than IDLE.
- `pending` out PEND_W: queued events not yet started.
- `overflow` out 1: sticky; an event was lost.

## Operation
- The FSM has three states: IDLE, ON and OFF. A single down-counter `timer` is shared by ON and OFF.
- **Reset values:** state=IDLE, `led`=0, `busy`=0, `pending`=0, `overflow`=0, `timer`=0.
- **IDLE:**
  - If `pulse`=1 or `pending`≠0, go to ON.
  - Load `timer`=ON_CYCLES−1 and set `led`=1.
  - If `pulse`=0, decrement `pending`. If `pulse`=1, the pulse itself is consumed and `pending` is unchanged.
- **ON:**
  - `led`=1.
  - While `timer`≠0, decrement it.
  - When `timer`=0, go to OFF, load `timer`=OFF_CYCLES−1 and set `led`=0.
- **OFF:**
  - `led`=0.
  - While `timer`≠0, decrement it.
  - When `timer`=0: if `pending`≠0 or `pulse`=1, go directly to ON using the same load and consume rules as IDLE. Otherwise go to IDLE.
- **Queueing:** `pulse`=1 in ON or OFF increments `pending`, unless that cycle starts a new flash.
- **Simultaneous events:**
  - A decrement and an increment in the same cycle leave `pending` unchanged.
  - A `pulse` in the cycle that starts a flash is consumed directly, never queued.
- **Saturation:** an increment with `pending`=2^PEND_W−1 leaves `pending` unchanged and sets `overflow`=1.
- **Overflow clear:** `clr_ovf`=1 clears `overflow`. If an overflow occurs in the same cycle, set wins.
- **Timer width:** `$clog2(max(ON_CYCLES,OFF_CYCLES))`, with a minimum of 1 bit. The timer never wraps.
- **Reset mid-flash:** `led` drops immediately (asynchronously) and the queue is discarded.

## Timing
- **Latency:** `led` rises on the clock edge that samples `pulse`=1 in IDLE.
- **Flash shape:** `led` is high for exactly ON_CYCLES cycles and then low for at least OFF_CYCLES cycles.
- **Back-to-back flashes:** the period is exactly ON_CYCLES+OFF_CYCLES cycles with no IDLE cycle between them.
- **Outputs:** all are registered; there are no combinational paths from input to output.
- **`busy`:** equals (state≠IDLE), registered alongside the state.
- **`pulse` handling:** no handshake. `pulse` is sampled every cycle, and each high cycle counts as one event.

## Structure
- **Shared package `blink_pkg`:** holds the state encoding localparams (IDLE=2'd0, ON=2'd1, OFF=2'd2) and the `clog2`-of-max helper.
- **Sub-module `cycle_timer`:**
  - Parameterised load-and-count-down counter.
  - Inputs: `clk`, `rst_n`, `load`, `load_val`. Output: `zero`.
  - Instantiated once; the FSM, the pending counter and the overflow logic stay in `event_blinker`.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
1. **Single pulse:** one `pulse` at cycle 10 → `led` high for cycles 11–14, low from 15; `busy` falls after cycle 17; `pending` stays 0.
2. **Back-to-back:** three pulses on consecutive cycles from IDLE → `pending` goes 1 then 2; three flashes with period 7; `pending` returns to 0.
3. **Overflow:** five pulses during one flash → `pending` saturates at 3 and `overflow`=1; exactly four flashes in total; `clr_ovf` then clears `overflow`.
4. **Collision at boundary:** `pulse` on the last OFF cycle with `pending`=1 → the next flash starts with no IDLE cycle; `pending` stays 1 for that cycle (one consumed, one added).
5. **Overflow set/clear race:** `clr_ovf`=1 in the same cycle as a saturating `pulse` → `overflow` stays 1.
6. **Reset mid-flash:** assert `rst_n`=0 mid-ON with `pending`=2 → `led`=0 immediately; after release all outputs are 0 and there are no further flashes.
